// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: read-side drain stage behind the async FIFO wrapper.
// Pops the FIFO through its empty/pop interface and absorbs the 1-cycle
// read latency. Words are presented as a valid/ready stream from a 2-entry
// buffer at one word per cycle, and a word is popped only when a slot is free.
// Define AFIFO_RD_STREAM_CNT_EN to build the delivered-word counter.
// Without it, word_cnt is tied to zero.
module afifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  arst_n,
  input  logic                  clr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state;
  logic                  infl;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  xfer;

  assign m_valid = (state != S_EMPTY);
  assign m_data  = head;
  assign xfer    = m_valid & m_ready;

  // Occupancy decode, plus the slot count that is committed after this cycle's transfer.
  always_comb begin
    occ = 2'd0;
    unique case (state)
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
    level = {1'b0, occ} + {2'b00, infl} - {2'b00, xfer};
  end

  // Pop only if the word returned next cycle is certain to have a slot.
  assign fifo_pop = arst_n & ~fifo_empty & ~clr & (level < 3'd2);

  // Buffer FSM: capture arriving words, shift tail to head on a transfer.
  always_ff @(posedge rdclk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_EMPTY;
      infl  <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else if (clr) begin
      state <= S_EMPTY;
      infl  <= 1'b0;
    end else begin
      infl <= fifo_pop;
      unique case (state)
        S_EMPTY: begin
          if (infl) begin
            head  <= fifo_rdata;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          if (infl && !xfer) begin
            tail  <= fifo_rdata;
            state <= S_TWO;
          end else if (infl && xfer) begin
            head <= fifo_rdata;
          end else if (xfer) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer) begin
            head <= tail;
            if (infl) tail <= fifo_rdata;
            else      state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // A word can never arrive into a full buffer that is not draining.
  a_no_overfill: assert property (@(posedge rdclk) disable iff (!arst_n)
    !(state == S_TWO && infl && !xfer));

`ifdef AFIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Count delivered words, wrapping naturally at the counter width.
  always_ff @(posedge rdclk or negedge arst_n) begin
    if (!arst_n)   cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 1'b1;
  end

  assign word_cnt = cnt_q;
`else
  assign word_cnt = '0;
`endif

endmodule

// File: doc/afifo_rd_stream.md
# afifo_rd_stream

Read-side drain stage that sits directly downstream of the async FIFO wrapper, in the `rdclk` domain. It pops words from the FIFO's empty/pop interface, absorbing the FIFO's 1-cycle read latency. It presents the words as a valid/ready stream through a 2-entry output buffer, sustaining one word per cycle without ever over-popping.

## Interface
- `DATA_WIDTH`, 8, FIFO word and stream data width.
- `CNT_WIDTH`, 16, width of the transferred-word counter.

- `rdclk`  in  1  read-domain clock; all state on its rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear: drops buffered and in-flight words, zeroes counter.
- `fifo_empty`  in  1  FIFO empty flag, `rdclk` domain.
- `fifo_rdata`  in  `DATA_WIDTH`  FIFO read data, valid the cycle after a pop.
- `fifo_pop`  out  1  FIFO read enable, combinational.
- `m_valid`  out  1  stream word available.
- `m_data`  out  `DATA_WIDTH`  stream word (head of buffer), registered.
- `m_ready`  in  1  downstream accepts word.
- `word_cnt`  out  `CNT_WIDTH`  words delivered downstream.

## Operation
- Buffer: 2 slots (head, tail), occupancy `occ` ∈ {0,1,2}.
  - States: EMPTY (occ=0), ONE (occ=1), TWO (occ=2).
  - `m_valid` = (occ≠0); `m_data` = head.
- `infl`: 1-bit register, set when a pop was issued last cycle (the FIFO word arrives this cycle).
- Transfer: `xfer = m_valid & m_ready`.
- `fifo_pop = !fifo_empty & !clr & (occ + infl − xfer < 2)`.
  - Guarantees no word is ever popped without a guaranteed slot.
- Word arrival (`infl`=1): `fifo_rdata` is captured this cycle.
  - Written to head if the buffer becomes empty after `xfer`, else to tail.
- On `xfer` with occ=2: tail shifts to head.
- State transitions (arr = `infl`):
  - EMPTY: arr → ONE; else stay.
  - ONE: arr & !xfer → TWO; !arr & xfer → EMPTY; else stay.
  - TWO: xfer & !arr → ONE; else stay.
  - TWO with !xfer & arr is impossible by the pop rule; assertion required.
- Ordering strictly FIFO; no word duplicated or dropped except by `clr`/reset.
- `word_cnt` increments on each `xfer`, wraps modulo 2^`CNT_WIDTH`.
- `clr`:
  - Next cycle: occ=0, `infl`=0 (any in-flight `fifo_rdata` is discarded), `word_cnt`=0.
  - `fifo_pop` is held low during the `clr` cycle.
- `m_valid` once high holds with stable `m_data` until `xfer`.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `word_cnt`=0, occ=0, `infl`=0; `fifo_pop` forced 0 while `arst_n`=0.
- Reset mid-operation discards all buffered and in-flight data immediately; first pop possible in the first clock after deassertion.
- Latency: `fifo_empty` falls in cycle N → `fifo_pop`=1 in N → data captured at end of N+1 → `m_valid`=1 in N+2.
- Throughput: 1 word/cycle with `m_ready` held high and FIFO non-empty.
- `m_ready` low: at most 2 pops after the stall begins; then `fifo_pop`=0 until `xfer`.
- `fifo_pop` depends combinationally on `m_ready`; `m_valid`/`m_data` have no combinational input paths.
- Simultaneous arrival and `xfer` at occ=1: occupancy stays 1, head takes the arriving word.

## Configuration
- `AFIFO_RD_STREAM_CNT_EN` defined: `word_cnt` counter implemented as above.
- Not defined: counter removed, `word_cnt` tied to 0; all other behaviour identical.

## Test plan
- Reset: drive `arst_n`=0 with `fifo_empty`=0 → `fifo_pop`=0, `m_valid`=0, `m_data`=0, `word_cnt`=0.
- Streaming: FIFO holds 0x01..0x10, `m_ready`=1 → `m_valid` 2 cycles after first pop; 16 consecutive words 0x01..0x10, one per cycle; `word_cnt`=16.
- Backpressure: FIFO holds 0xA0..0xA7, `m_ready`=0 → exactly 2 pops, `m_data`=0xA0 stable, occ=2; `m_ready`=1 → 0xA0..0xA7 in order, no gap after the restart cycle.
- Random `m_ready` (50%) against random `fifo_empty` over 10k cycles → output order matches the pop sequence, no drop or duplicate, no pop while occ+infl−xfer=2.
- `clr` asserted with occ=1, `infl`=1 → next cycle `m_valid`=0 and `word_cnt`=0; the in-flight word is never output; the next popped word is output.
- Counter wrap (`CNT_WIDTH`=4): 17 transfers → `word_cnt`=1; with the macro undefined → `word_cnt`=0 throughout.
